// File: rtl/rs_pool.sv
// rs_pool: parametrised reservation-station pool.
// Accepts dispatched instructions into the lowest free station, snoops two
// result buses for missing operands, and presents the oldest fully-ready
// station to the functional unit over a valid/ready handshake.
// Accept order is kept in an age matrix: r_older[i][j] set means station i
// was accepted before station j. Only rows/columns of busy stations matter.

module rs_pool #(
    parameter int DEPTH    = 2,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 4,
    parameter int OP_W     = 4,
    parameter int REG_W    = 4,
    parameter int TAG_BASE = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [OP_W-1:0]              i_in_op,
    input  logic [REG_W-1:0]             i_in_dst,
    input  logic [DATA_W-1:0]            i_in_v0,
    input  logic [DATA_W-1:0]            i_in_v1,
    input  logic                         i_in_r0,
    input  logic                         i_in_r1,
    input  logic [TAG_W-1:0]             i_in_s0,
    input  logic [TAG_W-1:0]             i_in_s1,
    output logic [TAG_W-1:0]             o_alloc_tag,
    output logic [$clog2(DEPTH+1)-1:0]   o_filled,
    input  logic                         i_cdbA_valid,
    input  logic [TAG_W-1:0]             i_cdbA_tag,
    input  logic [DATA_W-1:0]            i_cdbA_data,
    input  logic                         i_cdbB_valid,
    input  logic [TAG_W-1:0]             i_cdbB_tag,
    input  logic [DATA_W-1:0]            i_cdbB_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [OP_W-1:0]              o_out_op,
    output logic [REG_W-1:0]             o_out_dst,
    output logic [TAG_W-1:0]             o_out_tag,
    output logic [DATA_W-1:0]            o_out_v0,
    output logic [DATA_W-1:0]            o_out_v1
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Station state
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_r0;
    logic [DEPTH-1:0]  r_r1;
    logic [OP_W-1:0]   r_op  [DEPTH];
    logic [REG_W-1:0]  r_dst [DEPTH];
    logic [DATA_W-1:0] r_v0  [DEPTH];
    logic [DATA_W-1:0] r_v1  [DEPTH];
    logic [TAG_W-1:0]  r_s0  [DEPTH];
    logic [TAG_W-1:0]  r_s1  [DEPTH];
    logic [DEPTH-1:0]  r_older [DEPTH];

    logic [IDX_W-1:0]  w_free_idx;
    logic [CNT_W-1:0]  w_filled;
    logic [DEPTH-1:0]  w_elig;
    logic [DEPTH-1:0]  w_blocked;
    logic [DEPTH-1:0]  w_pick;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_sel_any;
    logic              w_accept;
    logic              w_release;
    logic [DATA_W:0]   w_acc0;
    logic [DATA_W:0]   w_acc1;
    logic [DATA_W:0]   w_nx0 [DEPTH];
    logic [DATA_W:0]   w_nx1 [DEPTH];

    // Resolve one operand against the result buses: {ready, value}.
    // An already-ready operand is never overwritten; bus A wins over bus B.
    function automatic logic [DATA_W:0] snoop(
        input logic              rdy,
        input logic [DATA_W-1:0] val,
        input logic [TAG_W-1:0]  src,
        input logic              a_v,
        input logic [TAG_W-1:0]  a_t,
        input logic [DATA_W-1:0] a_d,
        input logic              b_v,
        input logic [TAG_W-1:0]  b_t,
        input logic [DATA_W-1:0] b_d
    );
        if (rdy)
            return {1'b1, val};
        else if (a_v && (a_t == src))
            return {1'b1, a_d};
        else if (b_v && (b_t == src))
            return {1'b1, b_d};
        else
            return {1'b0, val};
    endfunction

    // Lowest free station and busy count
    always_comb begin
        w_free_idx = IDX_W'(DEPTH-1);
        w_filled   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!r_busy[i])
                w_free_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_filled = w_filled + CNT_W'(r_busy[i]);
        end
    end

    // Oldest eligible station: eligible and no older eligible station exists
    always_comb begin
        w_elig    = r_busy & r_r0 & r_r1;
        w_blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && w_elig[j] && r_older[j][i])
                    w_blocked[i] = 1'b1;
            end
        end
        w_pick    = w_elig & ~w_blocked;
        w_sel_idx = '0;
        w_sel_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_pick[i]) begin
                w_sel_idx = IDX_W'(i);
                w_sel_any = 1'b1;
            end
        end
    end

    // Operand resolution for the incoming instruction and for every station
    always_comb begin
        w_acc0 = snoop(i_in_r0, i_in_v0, i_in_s0,
                       i_cdbA_valid, i_cdbA_tag, i_cdbA_data,
                       i_cdbB_valid, i_cdbB_tag, i_cdbB_data);
        w_acc1 = snoop(i_in_r1, i_in_v1, i_in_s1,
                       i_cdbA_valid, i_cdbA_tag, i_cdbA_data,
                       i_cdbB_valid, i_cdbB_tag, i_cdbB_data);
        for (int i = 0; i < DEPTH; i++) begin
            w_nx0[i] = snoop(r_r0[i], r_v0[i], r_s0[i],
                             i_cdbA_valid, i_cdbA_tag, i_cdbA_data,
                             i_cdbB_valid, i_cdbB_tag, i_cdbB_data);
            w_nx1[i] = snoop(r_r1[i], r_v1[i], r_s1[i],
                             i_cdbA_valid, i_cdbA_tag, i_cdbA_data,
                             i_cdbB_valid, i_cdbB_tag, i_cdbB_data);
        end
    end

    // Handshake qualifiers; in_ready reflects pre-edge state only
    always_comb begin
        o_in_ready = ~&r_busy;
        w_accept   = i_in_valid && o_in_ready;
        w_release  = w_sel_any && i_out_ready;
    end

    // Station update: flush/reset clear, accept loads, release frees, wakeup
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_busy <= '0;
            r_r0   <= '0;
            r_r1   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]    <= '0;
                r_dst[i]   <= '0;
                r_v0[i]    <= '0;
                r_v1[i]    <= '0;
                r_s0[i]    <= '0;
                r_s1[i]    <= '0;
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept && (w_free_idx == IDX_W'(i))) begin
                    // New arrival is younger than everything already held
                    r_busy[i]  <= 1'b1;
                    r_op[i]    <= i_in_op;
                    r_dst[i]   <= i_in_dst;
                    r_r0[i]    <= w_acc0[DATA_W];
                    r_v0[i]    <= w_acc0[DATA_W-1:0];
                    r_s0[i]    <= i_in_s0;
                    r_r1[i]    <= w_acc1[DATA_W];
                    r_v1[i]    <= w_acc1[DATA_W-1:0];
                    r_s1[i]    <= i_in_s1;
                    r_older[i] <= '0;
                end else begin
                    if (w_release && (w_sel_idx == IDX_W'(i)))
                        r_busy[i] <= 1'b0;
                    if (r_busy[i]) begin
                        r_r0[i] <= w_nx0[i][DATA_W];
                        r_v0[i] <= w_nx0[i][DATA_W-1:0];
                        r_r1[i] <= w_nx1[i][DATA_W];
                        r_v1[i] <= w_nx1[i][DATA_W-1:0];
                    end
                    if (w_accept)
                        r_older[i][w_free_idx] <= 1'b1;
                end
            end
        end
    end

    // Presented station fields, zero when nothing is ready
    always_comb begin
        o_alloc_tag = TAG_W'(TAG_BASE) + TAG_W'(w_free_idx);
        o_filled    = w_filled;
        o_out_valid = w_sel_any;
        o_out_op    = '0;
        o_out_dst   = '0;
        o_out_tag   = '0;
        o_out_v0    = '0;
        o_out_v1    = '0;
        if (w_sel_any) begin
            o_out_op  = r_op[w_sel_idx];
            o_out_dst = r_dst[w_sel_idx];
            o_out_tag = TAG_W'(TAG_BASE) + TAG_W'(w_sel_idx);
            o_out_v0  = r_v0[w_sel_idx];
            o_out_v1  = r_v1[w_sel_idx];
        end
    end

endmodule

// File: tb/tb_rs_pool.sv
// Testbench for rs_pool: directed scenarios on a DEPTH=2/TAG_BASE=0 pool,
// tag-range and randomized checks on a DEPTH=4/TAG_BASE=2 pool fed the same
// inputs, compared against an accept-ordered queue model.

module tb_rs_pool;

    typedef struct {
        int          idx;
        logic [3:0]  op;
        logic [3:0]  dst;
        logic [15:0] v0;
        logic [15:0] v1;
        logic        r0;
        logic        r1;
        logic [3:0]  s0;
        logic [3:0]  s1;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_r0, in_r1, out_ready;
    logic [3:0]  in_op, in_dst, in_s0, in_s1;
    logic [15:0] in_v0, in_v1;
    logic        cdbA_valid, cdbB_valid;
    logic [3:0]  cdbA_tag, cdbB_tag;
    logic [15:0] cdbA_data, cdbB_data;

    logic        a_in_ready, a_out_valid;
    logic [3:0]  a_alloc_tag, a_out_op, a_out_dst, a_out_tag;
    logic [1:0]  a_filled;
    logic [15:0] a_out_v0, a_out_v1;

    logic        b_in_ready, b_out_valid;
    logic [3:0]  b_alloc_tag, b_out_op, b_out_dst, b_out_tag;
    logic [2:0]  b_filled;
    logic [15:0] b_out_v0, b_out_v1;

    int n_tests = 0;
    int n_fail  = 0;

    rs_pool #(.DEPTH(2), .DATA_W(16), .TAG_W(4), .OP_W(4), .REG_W(4), .TAG_BASE(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(a_in_ready),
        .i_in_op(in_op), .i_in_dst(in_dst), .i_in_v0(in_v0), .i_in_v1(in_v1),
        .i_in_r0(in_r0), .i_in_r1(in_r1), .i_in_s0(in_s0), .i_in_s1(in_s1),
        .o_alloc_tag(a_alloc_tag), .o_filled(a_filled),
        .i_cdbA_valid(cdbA_valid), .i_cdbA_tag(cdbA_tag), .i_cdbA_data(cdbA_data),
        .i_cdbB_valid(cdbB_valid), .i_cdbB_tag(cdbB_tag), .i_cdbB_data(cdbB_data),
        .o_out_valid(a_out_valid), .i_out_ready(out_ready),
        .o_out_op(a_out_op), .o_out_dst(a_out_dst), .o_out_tag(a_out_tag),
        .o_out_v0(a_out_v0), .o_out_v1(a_out_v1)
    );

    rs_pool #(.DEPTH(4), .DATA_W(16), .TAG_W(4), .OP_W(4), .REG_W(4), .TAG_BASE(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(b_in_ready),
        .i_in_op(in_op), .i_in_dst(in_dst), .i_in_v0(in_v0), .i_in_v1(in_v1),
        .i_in_r0(in_r0), .i_in_r1(in_r1), .i_in_s0(in_s0), .i_in_s1(in_s1),
        .o_alloc_tag(b_alloc_tag), .o_filled(b_filled),
        .i_cdbA_valid(cdbA_valid), .i_cdbA_tag(cdbA_tag), .i_cdbA_data(cdbA_data),
        .i_cdbB_valid(cdbB_valid), .i_cdbB_tag(cdbB_tag), .i_cdbB_data(cdbB_data),
        .o_out_valid(b_out_valid), .i_out_ready(out_ready),
        .o_out_op(b_out_op), .o_out_dst(b_out_dst), .o_out_tag(b_out_tag),
        .o_out_v0(b_out_v0), .o_out_v1(b_out_v1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_r0 = 0; in_r1 = 0; out_ready = 0;
        in_op = 0; in_dst = 0; in_s0 = 0; in_s1 = 0; in_v0 = 0; in_v1 = 0;
        cdbA_valid = 0; cdbA_tag = 0; cdbA_data = 0;
        cdbB_valid = 0; cdbB_tag = 0; cdbB_data = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
        n_tests++; if (a_filled !== 2'd0) begin n_fail++; $display("FAIL reset_filled got %0d exp 0", a_filled); end
        n_tests++; if (a_alloc_tag !== 4'd0) begin n_fail++; $display("FAIL reset_alloc_tag got %0d exp 0", a_alloc_tag); end
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
        n_tests++; if (a_out_v0 !== 16'h0 || a_out_v1 !== 16'h0 || a_out_tag !== 4'd0) begin n_fail++; $display("FAIL reset_out_data got v0=%h v1=%h tag=%0d exp zeros", a_out_v0, a_out_v1, a_out_tag); end
        n_tests++; if (b_alloc_tag !== 4'd2) begin n_fail++; $display("FAIL reset_b_alloc_tag got %0d exp 2", b_alloc_tag); end
    endtask

    task automatic test_single();
        idle(); in_valid = 1; in_op = 1; in_dst = 3; in_v0 = 16'h0005; in_v1 = 16'h0007; in_r0 = 1; in_r1 = 1;
        tick(); idle();
        n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", a_out_valid); end
        n_tests++; if (a_out_tag !== 4'd0 || a_out_op !== 4'd1 || a_out_dst !== 4'd3) begin n_fail++; $display("FAIL single_fields got tag=%0d op=%0d dst=%0d exp 0/1/3", a_out_tag, a_out_op, a_out_dst); end
        n_tests++; if (a_out_v0 !== 16'h0005 || a_out_v1 !== 16'h0007) begin n_fail++; $display("FAIL single_ops got %h/%h exp 0005/0007", a_out_v0, a_out_v1); end
        n_tests++; if (a_filled !== 2'd1) begin n_fail++; $display("FAIL single_filled got %0d exp 1", a_filled); end
        out_ready = 1; tick(); idle();
        n_tests++; if (a_filled !== 2'd0 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_release got filled=%0d valid=%b exp 0/0", a_filled, a_out_valid); end
    endtask

    task automatic test_wakeup_two();
        idle(); in_valid = 1; in_r0 = 0; in_s0 = 2; in_r1 = 1; in_v1 = 16'h0011;
        tick(); in_v1 = 16'h0022; tick();
        n_tests++; if (a_in_ready !== 1'b0 || a_filled !== 2'd2) begin n_fail++; $display("FAIL wake_full got ready=%b filled=%0d exp 0/2", a_in_ready, a_filled); end
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL wake_waiting got valid=%b exp 0", a_out_valid); end
        tick(); idle();
        n_tests++; if (a_filled !== 2'd2) begin n_fail++; $display("FAIL wake_no_third got filled=%0d exp 2", a_filled); end
        cdbB_valid = 1; cdbB_tag = 2; cdbB_data = 16'h00AA; tick(); idle();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_tag !== 4'd0 || a_out_v0 !== 16'h00AA || a_out_v1 !== 16'h0011) begin n_fail++; $display("FAIL wake_first got v=%b tag=%0d v0=%h v1=%h exp 1/0/00aa/0011", a_out_valid, a_out_tag, a_out_v0, a_out_v1); end
        out_ready = 1; tick();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_tag !== 4'd1 || a_out_v0 !== 16'h00AA || a_out_v1 !== 16'h0022 || a_filled !== 2'd1) begin n_fail++; $display("FAIL wake_second got v=%b tag=%0d v0=%h v1=%h filled=%0d exp 1/1/00aa/0022/1", a_out_valid, a_out_tag, a_out_v0, a_out_v1, a_filled); end
        tick(); idle();
        n_tests++; if (a_filled !== 2'd0) begin n_fail++; $display("FAIL wake_drain got filled=%0d exp 0", a_filled); end
    endtask

    task automatic test_capture();
        idle(); in_valid = 1; in_op = 2; in_v0 = 16'h0009; in_r0 = 1; in_r1 = 0; in_s1 = 3;
        cdbA_valid = 1; cdbA_tag = 3; cdbA_data = 16'h1234;
        tick(); idle();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_v1 !== 16'h1234 || a_out_v0 !== 16'h0009) begin n_fail++; $display("FAIL capture got v=%b v0=%h v1=%h exp 1/0009/1234", a_out_valid, a_out_v0, a_out_v1); end
        out_ready = 1; tick(); idle();
        n_tests++; if (a_filled !== 2'd0) begin n_fail++; $display("FAIL capture_drain got filled=%0d exp 0", a_filled); end
    endtask

    task automatic test_cdb_priority();
        idle(); in_valid = 1; in_r0 = 0; in_s0 = 2; in_r1 = 1; in_v1 = 16'h0005;
        tick(); idle();
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL prio_waiting got valid=%b exp 0", a_out_valid); end
        cdbA_valid = 1; cdbA_tag = 2; cdbA_data = 16'h0001;
        cdbB_valid = 1; cdbB_tag = 2; cdbB_data = 16'h0002;
        tick(); idle();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_v0 !== 16'h0001) begin n_fail++; $display("FAIL prio_busA got v=%b v0=%h exp 1/0001", a_out_valid, a_out_v0); end
        out_ready = 1; tick(); idle();
        n_tests++; if (a_filled !== 2'd0) begin n_fail++; $display("FAIL prio_drain got filled=%0d exp 0", a_filled); end
    endtask

    task automatic test_full_release();
        idle(); in_valid = 1; in_r0 = 1; in_r1 = 1; in_v0 = 16'h0010;
        tick(); in_v0 = 16'h0020; tick();
        n_tests++; if (a_filled !== 2'd2 || a_in_ready !== 1'b0 || a_out_tag !== 4'd0 || a_out_v0 !== 16'h0010) begin n_fail++; $display("FAIL full_state got filled=%0d ready=%b tag=%0d v0=%h exp 2/0/0/0010", a_filled, a_in_ready, a_out_tag, a_out_v0); end
        in_v0 = 16'h0030; out_ready = 1; tick();
        n_tests++; if (a_filled !== 2'd1 || a_in_ready !== 1'b1 || a_alloc_tag !== 4'd0) begin n_fail++; $display("FAIL full_release_only got filled=%0d ready=%b alloc=%0d exp 1/1/0", a_filled, a_in_ready, a_alloc_tag); end
        n_tests++; if (a_out_tag !== 4'd1 || a_out_v0 !== 16'h0020) begin n_fail++; $display("FAIL full_next got tag=%0d v0=%h exp 1/0020", a_out_tag, a_out_v0); end
        out_ready = 0; tick(); idle();
        n_tests++; if (a_filled !== 2'd2 || a_out_tag !== 4'd1 || a_out_v0 !== 16'h0020) begin n_fail++; $display("FAIL full_refill got filled=%0d tag=%0d v0=%h exp 2/1/0020", a_filled, a_out_tag, a_out_v0); end
        out_ready = 1; tick();
        n_tests++; if (a_out_tag !== 4'd0 || a_out_v0 !== 16'h0030 || a_filled !== 2'd1) begin n_fail++; $display("FAIL full_young got tag=%0d v0=%h filled=%0d exp 0/0030/1", a_out_tag, a_out_v0, a_filled); end
        tick(); idle();
        n_tests++; if (a_filled !== 2'd0) begin n_fail++; $display("FAIL full_drain got filled=%0d exp 0", a_filled); end
    endtask

    task automatic test_flush_tagbase();
        idle(); flush = 1; tick(); idle();
        n_tests++; if (b_alloc_tag !== 4'd2 || b_filled !== 3'd0) begin n_fail++; $display("FAIL tb2_clean got alloc=%0d filled=%0d exp 2/0", b_alloc_tag, b_filled); end
        in_valid = 1; in_r0 = 1; in_r1 = 1; in_v0 = 16'h0001; tick();
        n_tests++; if (b_out_tag !== 4'd2 || b_alloc_tag !== 4'd3) begin n_fail++; $display("FAIL tb2_first got out_tag=%0d alloc=%0d exp 2/3", b_out_tag, b_alloc_tag); end
        in_v0 = 16'h0002; tick(); idle();
        n_tests++; if (b_filled !== 3'd2 || b_out_tag !== 4'd2 || b_alloc_tag !== 4'd4 || a_filled !== 2'd2) begin n_fail++; $display("FAIL tb2_second got b_filled=%0d out_tag=%0d alloc=%0d a_filled=%0d exp 2/2/4/2", b_filled, b_out_tag, b_alloc_tag, a_filled); end
        flush = 1; in_valid = 1; in_r0 = 1; in_r1 = 1; out_ready = 1; tick(); idle();
        n_tests++; if (a_filled !== 2'd0 || a_out_valid !== 1'b0 || a_alloc_tag !== 4'd0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_a got filled=%0d valid=%b alloc=%0d ready=%b exp 0/0/0/1", a_filled, a_out_valid, a_alloc_tag, a_in_ready); end
        n_tests++; if (a_out_v0 !== 16'h0 || a_out_tag !== 4'd0) begin n_fail++; $display("FAIL flush_a_data got v0=%h tag=%0d exp 0/0", a_out_v0, a_out_tag); end
        n_tests++; if (b_filled !== 3'd0 || b_alloc_tag !== 4'd2 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_b got filled=%0d alloc=%0d valid=%b exp 0/2/0", b_filled, b_alloc_tag, b_out_valid); end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int   sel, fidx;
        bit   used [4];
        bit   acc;
        idle(); rst = 1; tick(); rst = 0;
        for (int c = 0; c < 800; c++) begin
            sel = -1;
            for (int k = 0; k < q.size(); k++)
                if (sel < 0 && q[k].r0 && q[k].r1) sel = k;
            for (int u = 0; u < 4; u++) used[u] = 0;
            for (int k = 0; k < q.size(); k++) used[q[k].idx] = 1;
            fidx = -1;
            for (int u = 3; u >= 0; u--) if (!used[u]) fidx = u;

            n_tests++; if (b_filled !== 3'(q.size())) begin n_fail++; if (n_fail < 40) $display("FAIL rand_filled c=%0d got %0d exp %0d", c, b_filled, q.size()); end
            n_tests++; if (b_in_ready !== (q.size() < 4)) begin n_fail++; if (n_fail < 40) $display("FAIL rand_in_ready c=%0d got %b exp %b", c, b_in_ready, q.size() < 4); end
            if (fidx >= 0) begin
                n_tests++; if (b_alloc_tag !== 4'(2 + fidx)) begin n_fail++; if (n_fail < 40) $display("FAIL rand_alloc c=%0d got %0d exp %0d", c, b_alloc_tag, 2 + fidx); end
            end
            n_tests++; if (b_out_valid !== (sel >= 0)) begin n_fail++; if (n_fail < 40) $display("FAIL rand_valid c=%0d got %b exp %b", c, b_out_valid, sel >= 0); end
            if (sel >= 0) begin
                n_tests++;
                if (b_out_tag !== 4'(2 + q[sel].idx) || b_out_op !== q[sel].op || b_out_dst !== q[sel].dst ||
                    b_out_v0 !== q[sel].v0 || b_out_v1 !== q[sel].v1) begin
                    n_fail++;
                    if (n_fail < 40) $display("FAIL rand_fields c=%0d got tag=%0d op=%0d dst=%0d v0=%h v1=%h exp tag=%0d op=%0d dst=%0d v0=%h v1=%h",
                        c, b_out_tag, b_out_op, b_out_dst, b_out_v0, b_out_v1,
                        2 + q[sel].idx, q[sel].op, q[sel].dst, q[sel].v0, q[sel].v1);
                end
            end

            flush      = ($urandom_range(0, 39) == 0);
            in_valid   = ($urandom_range(0, 9) < 6);
            in_op      = 4'($urandom_range(0, 15));
            in_dst     = 4'($urandom_range(0, 15));
            in_v0      = 16'($urandom);
            in_v1      = 16'($urandom);
            in_r0      = ($urandom_range(0, 1) == 1);
            in_r1      = ($urandom_range(0, 1) == 1);
            in_s0      = 4'($urandom_range(0, 3));
            in_s1      = 4'($urandom_range(0, 3));
            cdbA_valid = ($urandom_range(0, 9) < 4);
            cdbA_tag   = 4'($urandom_range(0, 3));
            cdbA_data  = 16'($urandom);
            cdbB_valid = ($urandom_range(0, 9) < 4);
            cdbB_tag   = 4'($urandom_range(0, 3));
            cdbB_data  = 16'($urandom);
            out_ready  = ($urandom_range(0, 1) == 1);

            if (flush) begin
                q.delete();
            end else begin
                acc = in_valid && (q.size() < 4);
                if (sel >= 0 && out_ready) q.delete(sel);
                for (int k = 0; k < q.size(); k++) begin
                    e = q[k];
                    if (!e.r0) begin
                        if (cdbA_valid && cdbA_tag == e.s0) begin e.v0 = cdbA_data; e.r0 = 1; end
                        else if (cdbB_valid && cdbB_tag == e.s0) begin e.v0 = cdbB_data; e.r0 = 1; end
                    end
                    if (!e.r1) begin
                        if (cdbA_valid && cdbA_tag == e.s1) begin e.v1 = cdbA_data; e.r1 = 1; end
                        else if (cdbB_valid && cdbB_tag == e.s1) begin e.v1 = cdbB_data; e.r1 = 1; end
                    end
                    q[k] = e;
                end
                if (acc) begin
                    e.idx = fidx; e.op = in_op; e.dst = in_dst;
                    e.v0 = in_v0; e.r0 = in_r0; e.s0 = in_s0;
                    e.v1 = in_v1; e.r1 = in_r1; e.s1 = in_s1;
                    if (!e.r0) begin
                        if (cdbA_valid && cdbA_tag == in_s0) begin e.v0 = cdbA_data; e.r0 = 1; end
                        else if (cdbB_valid && cdbB_tag == in_s0) begin e.v0 = cdbB_data; e.r0 = 1; end
                    end
                    if (!e.r1) begin
                        if (cdbA_valid && cdbA_tag == in_s1) begin e.v1 = cdbA_data; e.r1 = 1; end
                        else if (cdbB_valid && cdbB_tag == in_s1) begin e.v1 = cdbB_data; e.r1 = 1; end
                    end
                    q.push_back(e);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_single();
        test_wakeup_two();
        test_capture();
        test_cdb_priority();
        test_full_release();
        test_flush_tagbase();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_pool.md
# rs_pool

Parametrised reservation-station pool for the out-of-order core, generalising the fixed two-entry float and load stations into one reusable block. It accepts decoded instructions from dispatch, snoops two result buses (float bus and load bus) for missing operands, and hands the oldest ready entry to its functional unit over a valid/ready handshake. One instance per functional unit; each instance owns a distinct tag range.

## Interface
- DEPTH, 2: number of stations (2..8)
- DATA_W, 16: operand/result width
- TAG_W, 4: source-tag width
- OP_W, 4: opcode width
- REG_W, 4: destination register index width
- TAG_BASE, 0: tag of station 0; station i has tag TAG_BASE+i
- One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state changes on posedge
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all stations (taken-branch squash)
- in_valid  in  1  dispatch presents an instruction
- in_ready  out  1  pool has a free station
- in_op / in_dst  in  OP_W / REG_W  opcode, destination register
- in_v0, in_v1  in  DATA_W  operand value (valid when matching r bit set)
- in_r0, in_r1  in  1  operand already available
- in_s0, in_s1  in  TAG_W  producing tag when operand not available
- alloc_tag  out  TAG_W  tag the next accepted instruction receives
- filled  out  clog2(DEPTH+1)  number of busy stations
- cdbA_valid, cdbB_valid  in  1  result bus strobes
- cdbA_tag, cdbB_tag  in  TAG_W  result bus tags
- cdbA_data, cdbB_data  in  DATA_W  result bus values
- out_valid  out  1  a ready station is presented
- out_ready  in  1  functional unit accepts
- out_op / out_dst / out_tag  out  OP_W / REG_W / TAG_W  selected station fields
- out_v0, out_v1  out  DATA_W  selected station operands

## Operation
- Station fields: busy, op, dst, v0/r0/s0, v1/r1/s1, age rank.
- Accept: in_valid && in_ready && !flush at edge writes the lowest-indexed free station; alloc_tag = TAG_BASE + that index (TAG_BASE+DEPTH-1 undefined-but-stable when full; ignore).
- Accept-cycle capture: if in_rX=0 and a CDB strobes the same cycle with tag == in_sX, station stores that CDB data with rX=1.
- Wakeup: each busy station with rX=0 compares sX against both buses every cycle; on match stores data, sets rX=1. Both buses match same operand: cdbA wins. Both operands may wake in one cycle.
- Select: station eligible when busy && r0 && r1. Oldest-accepted eligible station is presented (strict accept order, maintained by age matrix or rank; ties impossible).
- Release: out_valid && out_ready frees the presented station at that edge; other stations keep relative order.
- Accept and release same edge allowed even when full: in_ready reflects state before edge, so full pool stays unaccepting that cycle; freed slot usable next cycle.
- filled = count of busy stations; in_ready = (filled < DEPTH).
- flush: all stations cleared at the edge; overrides accept and release in that cycle; out_valid ignored by FU on flush cycle.

## Timing
- Reset values: all stations free, in_ready=1, filled=0, alloc_tag=TAG_BASE, out_valid=0, out_* data 0.
- Outputs out_* are combinational from registered station state (no input-to-output path from in_* or cdb*).
- Instruction accepted with both operands ready at edge t: out_valid high in cycle t+1.
- Operand woken by CDB at edge t: station eligible in cycle t+1.
- out_valid held with stable fields while out_ready=0 and no flush (CDB activity cannot change a ready station).
- Reset or flush mid-operation: next cycle identical to reset state.

## Test plan
- Reset then accept op=1 dst=3 v0=0x0005 v1=0x0007 both ready -> next cycle out_valid=1, out_tag=0, out_v0=5, out_v1=7; out_ready=1 -> filled returns 0.
- DEPTH=2: accept two with r0=0 s0=2, third in_valid -> in_ready=0, filled=2; cdbB tag 2 data 0x00AA -> both wake, present oldest (tag 0) first, then tag 1, both v0=0x00AA.
- Accept with in_r1=0 in_s1=3 while cdbA_tag=3 data 0x1234 same cycle -> station ready next cycle, out_v1=0x1234.
- cdbA and cdbB both tag 2 (0x0001 / 0x0002) same cycle on waiting operand -> captured 0x0001.
- Full pool, out_ready=1 and in_valid=1 same cycle -> release only; next cycle in_ready=1, accept lands in freed index, alloc_tag matches.
- Two busy stations, assert flush with simultaneous in_valid -> next cycle filled=0, out_valid=0, alloc_tag=TAG_BASE; TAG_BASE=2 instance issues tags 2,3.
